// File: rtl/reg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// reg_arbiter_pkg
// Shared definitions for the register-write arbiter: requester count, index
// and burst-counter widths, burst length limit, default data width, the
// arbiter state encoding and a one-hot helper.
// -----------------------------------------------------------------------------
package reg_arbiter_pkg;

    localparam int NREQ      = 4;   // number of requesters (power of two)
    localparam int IDXW      = 2;   // width of a requester index
    localparam int BURST_MAX = 7;   // burst counter saturation value
    localparam int CNTW      = 3;   // width of the burst counter
    localparam int DWORD     = 32;  // default write data width

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // no grant
        ST_SINGLE = 2'd1,   // one-cycle grant
        ST_BURST  = 2'd2    // locked multi-cycle grant
    } arb_state_e;

    function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/reg_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Round-robin next-winner search. Scans eligible starting at ptr+1 (mod NREQ)
// and returns the first set bit; ptr itself is scanned last.
//   eligible : in  NREQ  candidate requesters
//   ptr      : in  IDXW  index of the previous winner
//   valid    : out 1     some requester is eligible
//   idx      : out IDXW  index of the winner (0 when !valid)
// -----------------------------------------------------------------------------
module rr_pick
    import reg_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] eligible,
    input  logic [IDXW-1:0] ptr,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    logic [IDXW-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest eligible bit
    // (ptr+1) is written last and wins. The index add wraps naturally
    // because NREQ is a power of two.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_cand = ptr + IDXW'(i);
            if (eligible[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// -----------------------------------------------------------------------------
// reg_arbiter
// Arbitrates four requesters onto the write port of an external shared
// register. Round-robin for single writes; a requester holding lock gets a
// burst that is force-released after BURST_MAX+1 cycles if anyone else waits.
//   clk     : in  1           clock, rising edge
//   rst     : in  1           asynchronous active-low reset
//   req     : in  NREQ        per-requester write request (level)
//   lock    : in  NREQ        per-requester burst request
//   din     : in  NREQ*WIDTH  requester data, slice i = din[i*WIDTH +: WIDTH]
//   gnt     : out NREQ        registered one-hot grant
//   wr_en   : out 1           write enable (OR of gnt)
//   wr_data : out WIDTH       data of the granted requester, 0 when idle
//   wr_src  : out IDXW        index of the granted requester, 0 when idle
//   busy    : out 1           burst in progress
// -----------------------------------------------------------------------------
module reg_arbiter
    import reg_arbiter_pkg::*;
#(
    parameter int WIDTH = DWORD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic                  wr_en,
    output logic [WIDTH-1:0]      wr_data,
    output logic [IDXW-1:0]       wr_src,
    output logic                  busy
);

    arb_state_e      r_state;
    logic [IDXW-1:0] r_ptr;     // last winner; search starts one past it
    logic [IDXW-1:0] r_own;     // current grantee, 0 when idle
    logic [CNTW-1:0] r_cnt;     // burst length counter, saturating
    logic [NREQ-1:0] r_mask;    // previous SINGLE grantee, excluded once
    logic [NREQ-1:0] r_gnt;

    logic [NREQ-1:0] w_own_oh;
    logic            w_hold;
    logic            w_others;
    logic            w_force;
    logic            w_keep;
    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_elig;
    logic            w_win_vld;
    logic [IDXW-1:0] w_win_idx;
    logic [WIDTH-1:0] w_din [NREQ];

    // ------------------------------------------------------------------
    // Arbitration inputs
    // ------------------------------------------------------------------
    assign w_own_oh = onehot(r_own);

    // Owner still asking for the burst.
    assign w_hold   = (r_state == ST_BURST) && req[r_own] && lock[r_own];

    // Someone other than the owner wants the register. r_mask is always
    // clear in BURST, so raw req is the eligibility here.
    assign w_others = |(req & ~w_own_oh);

    // Saturated burst with a waiting requester: hand over, skipping owner.
    assign w_force  = w_hold && (r_cnt == CNTW'(BURST_MAX)) && w_others;

    // Burst simply continues; no arbitration this edge.
    assign w_keep   = w_hold && !w_force;

    // When a burst ends because req/lock dropped, the owner is not masked:
    // if it still requests with lock low it competes normally (it sits at
    // ptr, so it is scanned last).
    assign w_mask   = r_mask | (w_force ? w_own_oh : '0);
    assign w_elig   = req & ~w_mask;

    rr_pick u_pick (
        .eligible (w_elig),
        .ptr      (r_ptr),
        .valid    (w_win_vld),
        .idx      (w_win_idx)
    );

    // ------------------------------------------------------------------
    // State machine: state, pointer, counter, mask and grant all update
    // together so the grant register is the single source for outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= IDXW'(NREQ - 1);  // requester 0 is first after reset
            r_own   <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_gnt   <= '0;
        end else if (w_keep) begin
            if (r_cnt != CNTW'(BURST_MAX))
                r_cnt <= r_cnt + 1'b1;
        end else if (w_win_vld) begin
            r_ptr <= w_win_idx;
            r_own <= w_win_idx;
            r_gnt <= onehot(w_win_idx);
            r_cnt <= '0;
            if (lock[w_win_idx]) begin
                r_state <= ST_BURST;
                r_mask  <= '0;
            end else begin
                r_state <= ST_SINGLE;
                r_mask  <= onehot(w_win_idx);  // no back-to-back single grant
            end
        end else begin
            r_state <= ST_IDLE;
            r_own   <= '0;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_gnt   <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Write port: only the registered grant steers the data mux, so req
    // never reaches the outputs combinationally.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NREQ; g++) begin : g_din
        assign w_din[g] = din[g*WIDTH +: WIDTH];
    end

    assign gnt     = r_gnt;
    assign wr_en   = |r_gnt;
    assign wr_src  = r_own;
    assign busy    = (r_state == ST_BURST);
    assign wr_data = wr_en ? w_din[r_own] : '0;

    // Grant is never more than one-hot.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(r_gnt));

endmodule

// File: tb/tb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_arbiter
// Directed bench for reg_arbiter: reset values, single grants, round-robin
// order, burst force-release, saturated burst, async reset mid-burst and
// burst end with hand-over.
// -----------------------------------------------------------------------------
module tb_reg_arbiter;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [3:0]    lock;
    logic [127:0]  din;
    logic [3:0]    gnt;
    logic          wr_en;
    logic [31:0]   wr_data;
    logic [1:0]    wr_src;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_d [4];

    reg_arbiter #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .din     (din),
        .gnt     (gnt),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_src  (wr_src),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one active edge and sample just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_gnt(input string tag, input int idx, input logic b);
        chk({tag, "/gnt"},     32'(gnt),     32'(1 << idx));
        chk({tag, "/wr_en"},   32'(wr_en),   32'd1);
        chk({tag, "/wr_data"}, wr_data,      exp_d[idx]);
        chk({tag, "/wr_src"},  32'(wr_src),  32'(idx));
        chk({tag, "/busy"},    32'(busy),    32'(b));
    endtask

    task automatic exp_idle(input string tag);
        chk({tag, "/gnt"},     32'(gnt),    32'd0);
        chk({tag, "/wr_en"},   32'(wr_en),  32'd0);
        chk({tag, "/wr_data"}, wr_data,     32'd0);
        chk({tag, "/wr_src"},  32'(wr_src), 32'd0);
        chk({tag, "/busy"},    32'(busy),   32'd0);
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        req  = '0;
        lock = '0;
        tick();
        tick();
        rst  = 1'b1;
    endtask

    initial begin
        exp_d[0] = 32'h0000_00A5;
        exp_d[1] = 32'hBBBB_0001;
        exp_d[2] = 32'hCCCC_0002;
        exp_d[3] = 32'hDDDD_0003;
        din  = {exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
        rst  = 1'b0;
        req  = '0;
        lock = '0;

        // Reset state while rst is held low across edges.
        tick();
        tick();
        exp_idle("reset");
        rst = 1'b1;

        // Lone single requester: granted, then one idle cycle, then again.
        req = 4'b0001;
        tick(); exp_gnt("single0_a", 0, 1'b0);
        tick(); exp_idle("single0_gap");
        tick(); exp_gnt("single0_b", 0, 1'b0);
        req = 4'b0000;
        tick(); exp_idle("single0_end");

        // All requesting without lock: 0,1,2,3,0 back to back.
        do_reset();
        req = 4'b1111;
        tick(); exp_gnt("rr_0", 0, 1'b0);
        tick(); exp_gnt("rr_1", 1, 1'b0);
        tick(); exp_gnt("rr_2", 2, 1'b0);
        tick(); exp_gnt("rr_3", 3, 1'b0);
        tick(); exp_gnt("rr_4", 0, 1'b0);
        req = 4'b0000;
        tick(); exp_idle("rr_end");

        // Burst by 0 with 1 waiting: 8 burst cycles, 1 cycle to 1, 0 resumes.
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick(); exp_gnt($sformatf("burst0_c%0d", i), 0, 1'b1);
        end
        tick(); exp_gnt("force_rel1", 1, 1'b0);
        tick(); exp_gnt("burst0_resume", 0, 1'b1);
        req  = 4'b0000;
        lock = 4'b0000;
        tick(); exp_idle("burst0_end");

        // Lone locked requester 2 for 12 cycles: never released.
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        for (int i = 0; i < 12; i++) begin
            tick(); exp_gnt($sformatf("burst2_c%0d", i), 2, 1'b1);
        end
        // Owner drops lock but keeps req, 1 also requesting: 1 wins (ptr=2).
        lock = 4'b0000;
        req  = 4'b0110;
        tick(); exp_gnt("burst2_drop_to1", 1, 1'b0);
        tick(); exp_gnt("after_drop_2", 2, 1'b0);
        req = 4'b0000;
        tick(); exp_idle("drop_end");

        // Same drop with 3 also requesting: 3 is nearest after ptr=2.
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        tick(); exp_gnt("burst2b", 2, 1'b1);
        lock = 4'b0000;
        req  = 4'b1110;
        tick(); exp_gnt("burst2b_drop_to3", 3, 1'b0);
        req = 4'b0000;
        tick(); exp_idle("drop3_end");

        // Asynchronous reset in cycle 3 of a burst, mid-cycle.
        do_reset();
        req  = 4'b0001;
        lock = 4'b0001;
        tick(); tick(); tick();
        exp_gnt("prerst_burst", 0, 1'b1);
        #3 rst = 1'b0;
        #1 exp_idle("rst_async");
        req  = 4'b1000;
        lock = 4'b0000;
        #2 rst = 1'b1;
        tick(); exp_gnt("post_rst3", 3, 1'b0);
        req = 4'b0000;
        tick(); exp_idle("post_rst_end");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
